alarm_snooze_fsm: RTL
=====================

# alarm_snooze_fsm

Alarm controller for the 12-hour clock. It holds a user-set alarm time and compares it against the live time from the clock state machine. It rings, supports a snooze, and auto-silences on timeout. It also sits upstream of the clock state machine: it steers the minute/hour increment buttons either to the alarm registers (set mode) or through to the clock.

## Interface
- `SNOOZE_MIN`, default 9: snooze length in minutes, legal 1..59.
- `RING_TIMEOUT_S`, default 60: seconds of unacknowledged ringing before auto-stop, legal 1..255.

- `clk_pi`  in  1  system clock, single clock domain.
- `rst_n_pi`  in  1  asynchronous, active-low reset.
- `clk_en_pi`  in  1  one-cycle pulse once per second, same pulse the clock state machine receives.
- `seconds_pi`  in  6  current seconds, 0..59.
- `minutes_pi`  in  6  current minutes, 0..59.
- `hours_pi`  in  4  current hours, 1..12.
- `set_alarm_pi`  in  1  level; high = increment buttons edit the alarm.
- `increment_minute_pi`  in  1  one-cycle button pulse.
- `increment_hour_pi`  in  1  one-cycle button pulse.
- `alarm_en_pi`  in  1  level; arm switch.
- `snooze_pi`  in  1  one-cycle pulse.
- `stop_pi`  in  1  one-cycle pulse.
- `clk_inc_minute_po`  out  1  minute increment forwarded to the clock.
- `clk_inc_hour_po`  out  1  hour increment forwarded to the clock.
- `alarm_minutes_po`  out  6  alarm minutes.
- `alarm_hours_po`  out  4  alarm hours.
- `ringing_po`  out  1  alarm sounding.
- `snoozing_po`  out  1  snooze pending.

## Operation
- **Reset values:**
  - alarm registers = 12:00
  - state IDLE
  - `ringing_po` = 0, `snoozing_po` = 0
  - snooze target = 12:00
  - timeout counter = 0
  - `tick_q` = 0
- **Button steering** (combinational, zero latency):
  - `clk_inc_minute_po` = `increment_minute_pi & ~set_alarm_pi`
  - `clk_inc_hour_po` = `increment_hour_pi & ~set_alarm_pi`
- **Alarm edit** (when `set_alarm_pi` = 1):
  - Minute pulse: 59→0, no carry into hours.
  - Hour pulse: 12→1.
  - Both pulses in one cycle: both registers update.
  - Editing is legal in every state and does not disturb the current ring or snooze.
- **Time-advance qualifier:** `tick_q` is `clk_en_pi` delayed one cycle. It marks the first cycle the clock presents the new time.
- **States:** IDLE, RINGING, SNOOZE. `ringing_po` = (state == RINGING). `snoozing_po` = (state == SNOOZE).
- **IDLE → RINGING** when all hold: `alarm_en_pi`, `tick_q`, `seconds_pi` = 0, `minutes_pi`/`hours_pi` equal the alarm registers.
  - Moving the clock into the alarm time manually does not ring.
- **RINGING:**
  - Timeout counter clears on entry and increments on each `clk_en_pi`.
  - `stop_pi` → IDLE.
  - `snooze_pi` → SNOOZE; latch the snooze target as current time + `SNOOZE_MIN` minutes.
  - Timeout: `clk_en_pi` while counter = `RING_TIMEOUT_S`−1 → IDLE.
- **Snooze target arithmetic:** 7-bit sum m + `SNOOZE_MIN`.
  - If ≥60: subtract 60 and advance the hour, 12→1.
  - Seconds are ignored.
- **SNOOZE:**
  - `stop_pi` → IDLE.
  - `tick_q` && `seconds_pi` = 0 && time equals the snooze target → RINGING, with the timeout counter cleared.
  - A snooze from that re-ring is allowed repeatedly.
- **Priority:**
  - Disarm: `alarm_en_pi` = 0 forces IDLE from any state, highest priority.
  - Then `stop_pi`, then `snooze_pi`, then timeout.
  - `snooze_pi` in IDLE or SNOOZE is ignored. `stop_pi` in IDLE is ignored.
  - If the alarm match and the snooze-target match coincide while in SNOOZE, result is RINGING (single event).

## Timing
- `clk_en_pi` sampled at edge N → clock shows HH:MM:00 after N → `tick_q` = 1 after N → `ringing_po` = 1 after edge N+1.
- `stop_pi`/`snooze_pi` sampled at edge K → outputs change after K. Snooze target is valid after K.
- Alarm registers update at the edge sampling the button pulse.
- Asynchronous reset mid-ring or mid-snooze: all outputs return to reset values immediately. Operation resumes at the first edge after `rst_n_pi` rises.

## Test plan
- **Reset:** assert `rst_n_pi` low during RINGING → `ringing_po` = 0, `snoozing_po` = 0, alarm = 12:00 without a clock edge. With `set_alarm_pi` = 0, a minute pulse → `clk_inc_minute_po` = 1 in the same cycle.
- **Edit and steering:** `set_alarm_pi` = 1, 6 hour pulses, 7 minute pulses → alarm 06:07, `clk_inc_*_po` never high. Then 53 more minute pulses → 06:00, with hours unchanged.
- **Trigger:** alarm 06:07, armed, tick advances time 06:06:59→06:07:00 → `ringing_po` = 1 exactly two edges after the tick. Same stimulus with `alarm_en_pi` = 0 → no ring.
- **Snooze:**
  - Snooze at 06:07:10 → ring clears and `snoozing_po` = 1. Tick into 06:16:00 → ring.
  - Snooze at 12:55:30 → ring at 01:04:00.
- **Timeout:** ring with `RING_TIMEOUT_S` = 60 → IDLE on the 60th tick. No re-ring during the rest of 06:07.
- **Priority:** `stop_pi` and `snooze_pi` in the same cycle while ringing → IDLE. Dropping `alarm_en_pi` during SNOOZE → IDLE, and the snooze target never rings.

Source files
------------

// File: rtl/alarm_snooze_fsm.sv
// Alarm controller for the 12-hour clock: holds the alarm time, rings on match,
// supports snooze and auto-timeout, and steers increment buttons to alarm or clock.
module alarm_snooze_fsm #(
  parameter int unsigned SNOOZE_MIN     = 9,
  parameter int unsigned RING_TIMEOUT_S = 60
) (
  input  logic       clk_pi,
  input  logic       rst_n_pi,
  input  logic       clk_en_pi,
  input  logic [5:0] seconds_pi,
  input  logic [5:0] minutes_pi,
  input  logic [3:0] hours_pi,
  input  logic       set_alarm_pi,
  input  logic       increment_minute_pi,
  input  logic       increment_hour_pi,
  input  logic       alarm_en_pi,
  input  logic       snooze_pi,
  input  logic       stop_pi,
  output logic       clk_inc_minute_po,
  output logic       clk_inc_hour_po,
  output logic [5:0] alarm_minutes_po,
  output logic [3:0] alarm_hours_po,
  output logic       ringing_po,
  output logic       snoozing_po
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic [6:0] LP_SNOOZE   = 7'(SNOOZE_MIN);
  localparam logic [7:0] LP_TMO_LAST = 8'(RING_TIMEOUT_S - 1);

  state_t     r_state, w_state_nxt;
  logic       r_tick_q;
  logic [5:0] r_alarm_min, w_alarm_min_nxt;
  logic [3:0] r_alarm_hr,  w_alarm_hr_nxt;
  logic [5:0] r_snz_min,   w_snz_min_nxt;
  logic [3:0] r_snz_hr,    w_snz_hr_nxt;
  logic [7:0] r_tmo_cnt,   w_tmo_cnt_nxt;

  logic [6:0] w_snz_sum;
  logic [5:0] w_snz_tgt_min;
  logic [3:0] w_snz_tgt_hr;
  logic       w_new_time;
  logic       w_alarm_match;
  logic       w_snz_match;

  assign clk_inc_minute_po = increment_minute_pi & ~set_alarm_pi;
  assign clk_inc_hour_po   = increment_hour_pi   & ~set_alarm_pi;

  assign alarm_minutes_po = r_alarm_min;
  assign alarm_hours_po   = r_alarm_hr;
  assign ringing_po       = (r_state == ST_RINGING);
  assign snoozing_po      = (r_state == ST_SNOOZE);

  // Matches only count on the first cycle of a freshly ticked time at :00,
  // so manually stepping the clock onto the alarm time never rings.
  assign w_new_time    = r_tick_q && (seconds_pi == 6'd0);
  assign w_alarm_match = w_new_time && (minutes_pi == r_alarm_min) && (hours_pi == r_alarm_hr);
  assign w_snz_match   = w_new_time && (minutes_pi == r_snz_min)   && (hours_pi == r_snz_hr);

  always_comb begin
    w_snz_sum     = {1'b0, minutes_pi} + LP_SNOOZE;
    w_snz_tgt_min = w_snz_sum[5:0];
    w_snz_tgt_hr  = hours_pi;
    if (w_snz_sum >= 7'd60) begin
      w_snz_tgt_min = 6'(w_snz_sum - 7'd60);
      w_snz_tgt_hr  = (hours_pi == 4'd12) ? 4'd1 : hours_pi + 4'd1;
    end
  end

  always_comb begin
    w_alarm_min_nxt = r_alarm_min;
    w_alarm_hr_nxt  = r_alarm_hr;
    if (set_alarm_pi) begin
      if (increment_minute_pi)
        w_alarm_min_nxt = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
      if (increment_hour_pi)
        w_alarm_hr_nxt  = (r_alarm_hr == 4'd12) ? 4'd1 : r_alarm_hr + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_snz_min_nxt = r_snz_min;
    w_snz_hr_nxt  = r_snz_hr;
    w_tmo_cnt_nxt = r_tmo_cnt;
    if (!alarm_en_pi) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_alarm_match) begin
            w_state_nxt   = ST_RINGING;
            w_tmo_cnt_nxt = '0;
          end
        end
        ST_RINGING: begin
          if (stop_pi) begin
            w_state_nxt = ST_IDLE;
          end else if (snooze_pi) begin
            w_state_nxt   = ST_SNOOZE;
            w_snz_min_nxt = w_snz_tgt_min;
            w_snz_hr_nxt  = w_snz_tgt_hr;
          end else if (clk_en_pi) begin
            if (r_tmo_cnt == LP_TMO_LAST)
              w_state_nxt = ST_IDLE;
            else
              w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
          end
        end
        ST_SNOOZE: begin
          // Alarm and snooze-target matches collapse into one re-ring event.
          if (stop_pi) begin
            w_state_nxt = ST_IDLE;
          end else if (w_snz_match || w_alarm_match) begin
            w_state_nxt   = ST_RINGING;
            w_tmo_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      r_state     <= ST_IDLE;
      r_tick_q    <= 1'b0;
      r_alarm_min <= '0;
      r_alarm_hr  <= 4'd12;
      r_snz_min   <= '0;
      r_snz_hr    <= 4'd12;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_q    <= clk_en_pi;
      r_alarm_min <= w_alarm_min_nxt;
      r_alarm_hr  <= w_alarm_hr_nxt;
      r_snz_min   <= w_snz_min_nxt;
      r_snz_hr    <= w_snz_hr_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
    end
  end

endmodule
